// File: rtl/water_reminder_timer.sv
// Drink-water reminder: counts minute ticks in two BCD digits, raises an alert when
// the programmed interval elapses, and handles acknowledge, snooze and missed-alert
// timeout with a three-state FSM. All outputs come straight from registers.
module water_reminder_timer #(
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned TIMEOUT_MIN = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,          // synchronous, active-low
  input  logic       i_minute_tick,
  input  logic [3:0] i_interval_tens,
  input  logic [3:0] i_interval_ones,
  input  logic       i_ack,
  input  logic       i_snooze,
  input  logic       i_clr_missed,
  output logic [3:0] o_min0,
  output logic [3:0] o_min1,
  output logic       o_alert,
  output logic [3:0] o_missed_count,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    StCounting = 2'b00,
    StAlert    = 2'b01,
    StSnooze   = 2'b10
  } state_e;

  state_e     r_state;
  logic [3:0] r_min0;
  logic [3:0] r_min1;
  logic       r_alert;
  logic [3:0] r_missed;

  logic       w_interval_bad;
  logic [7:0] w_interval;
  logic [7:0] w_count_bin;
  logic [7:0] w_limit;
  logic       w_hit;
  logic [3:0] w_min0_inc;
  logic [3:0] w_min1_inc;
  logic [3:0] w_missed_inc;

  // Effective interval: out-of-range digits or a zero interval fall back to 60 minutes.
  always_comb begin
    w_interval_bad = (i_interval_tens > 4'd9) || (i_interval_ones > 4'd9) ||
                     ((i_interval_tens == 4'd0) && (i_interval_ones == 4'd0));
    if (w_interval_bad) begin
      w_interval = 8'd60;
    end else begin
      w_interval = ({4'd0, i_interval_tens} * 8'd10) + {4'd0, i_interval_ones};
    end
  end

  // Binary view of the BCD count and the limit that applies in the current state.
  always_comb begin
    w_count_bin = ({4'd0, r_min1} * 8'd10) + {4'd0, r_min0};
    unique case (r_state)
      StAlert:  w_limit = 8'(TIMEOUT_MIN);
      StSnooze: w_limit = 8'(SNOOZE_MIN);
      default:  w_limit = w_interval;
    endcase
    // Compare with >= so that lowering the interval mid-count fires on the next tick.
    w_hit = (w_count_bin + 8'd1) >= w_limit;
  end

  // Next BCD count value and saturating missed-count increment.
  always_comb begin
    if (r_min0 == 4'd9) begin
      w_min0_inc = 4'd0;
      w_min1_inc = (r_min1 == 4'd9) ? 4'd0 : r_min1 + 4'd1;
    end else begin
      w_min0_inc = r_min0 + 4'd1;
      w_min1_inc = r_min1;
    end
    w_missed_inc = (r_missed == 4'd9) ? 4'd9 : r_missed + 4'd1;
  end

  // FSM, minute counter, alert flag and missed counter, all updated on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= StCounting;
      r_min0   <= 4'd0;
      r_min1   <= 4'd0;
      r_alert  <= 1'b0;
      r_missed <= 4'd0;
    end else begin
      unique case (r_state)
        StCounting: begin
          // snooze has no meaning here, so it neither acts nor blocks the tick
          if (i_ack) begin
            r_min0 <= 4'd0;
            r_min1 <= 4'd0;
          end else if (i_minute_tick) begin
            if (w_hit) begin
              r_state <= StAlert;
              r_alert <= 1'b1;
              r_min0  <= 4'd0;
              r_min1  <= 4'd0;
            end else begin
              r_min0 <= w_min0_inc;
              r_min1 <= w_min1_inc;
            end
          end
        end

        StAlert: begin
          if (i_ack) begin
            r_state <= StCounting;
            r_alert <= 1'b0;
            r_min0  <= 4'd0;
            r_min1  <= 4'd0;
          end else if (i_snooze) begin
            r_state <= StSnooze;
            r_alert <= 1'b0;
            r_min0  <= 4'd0;
            r_min1  <= 4'd0;
          end else if (i_minute_tick) begin
            if (w_hit) begin
              r_state  <= StCounting;
              r_alert  <= 1'b0;
              r_min0   <= 4'd0;
              r_min1   <= 4'd0;
              r_missed <= w_missed_inc;
            end else begin
              r_min0 <= w_min0_inc;
              r_min1 <= w_min1_inc;
            end
          end
        end

        StSnooze: begin
          if (i_ack) begin
            r_state <= StCounting;
            r_min0  <= 4'd0;
            r_min1  <= 4'd0;
          end else if (i_snooze) begin
            r_min0 <= 4'd0;
            r_min1 <= 4'd0;
          end else if (i_minute_tick) begin
            if (w_hit) begin
              r_state <= StAlert;
              r_alert <= 1'b1;
              r_min0  <= 4'd0;
              r_min1  <= 4'd0;
            end else begin
              r_min0 <= w_min0_inc;
              r_min1 <= w_min1_inc;
            end
          end
        end

        default: begin
          // unused encoding: recover to a clean COUNTING state
          r_state <= StCounting;
          r_alert <= 1'b0;
          r_min0  <= 4'd0;
          r_min1  <= 4'd0;
        end
      endcase

      // Clear overrides any timeout increment made above in the same cycle.
      if (i_clr_missed) begin
        r_missed <= 4'd0;
      end
    end
  end

  assign o_min0         = r_min0;
  assign o_min1         = r_min1;
  assign o_alert        = r_alert;
  assign o_missed_count = r_missed;
  assign o_state        = r_state;

endmodule

// File: tb/tb_water_reminder_timer.sv
// Self-checking bench for water_reminder_timer: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (BCD carry, timeout, snooze, reset).
module tb_water_reminder_timer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       ack;
  logic       snz;
  logic       clr;
  logic [3:0] o_min0;
  logic [3:0] o_min1;
  logic       o_alert;
  logic [3:0] o_missed_count;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] SC = 2'b00;
  localparam logic [1:0] SA = 2'b01;
  localparam logic [1:0] SS = 2'b10;

  water_reminder_timer #(
    .SNOOZE_MIN (5),
    .TIMEOUT_MIN(10)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_minute_tick  (tick),
    .i_interval_tens(tens),
    .i_interval_ones(ones),
    .i_ack          (ack),
    .i_snooze       (snz),
    .i_clr_missed   (clr),
    .o_min0         (o_min0),
    .o_min1         (o_min1),
    .o_alert        (o_alert),
    .o_missed_count (o_missed_count),
    .o_state        (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       tick;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ack;
    logic       snz;
    logic       clr;
    logic [3:0] e_min1;
    logic [3:0] e_min0;
    logic       e_alert;
    logic [3:0] e_missed;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [3:0] e1, input logic [3:0] e0,
                     input logic ea, input logic [3:0] em, input logic [1:0] es);
    n_checks++;
    if ({o_min1, o_min0, o_alert, o_missed_count, o_state} !== {e1, e0, ea, em, es}) begin
      n_fail++;
      $display("FAIL %s: got min=%h%h alert=%b missed=%h state=%b, required min=%h%h alert=%b missed=%h state=%b",
               name, o_min1, o_min0, o_alert, o_missed_count, o_state, e1, e0, ea, em, es);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic a, input logic s, input logic c);
    @(negedge clk);
    rst_n = r;
    tick  = t;
    ack   = a;
    snz   = s;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // From COUNTING with interval 01: one alert cycle that times out unanswered.
  task automatic miss_once(input logic [3:0] exp_missed);
    ticks(1);
    chk("miss_enter_alert", 4'd0, 4'd0, 1'b1, o_missed_count, SA);
    ticks(9);
    chk("miss_alert_09", 4'd0, 4'd9, 1'b1, o_missed_count, SA);
    ticks(1);
    chk("miss_timeout", 4'd0, 4'd0, 1'b0, exp_missed, SC);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; tens = 4'd0; ones = 4'd3;
    ack = 1'b0; snz = 1'b0; clr = 1'b0;

    //          rst  tk  tens   ones   ack snz clr   m1     m0     al  miss   st
    vecs[0]  = '{1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[1]  = '{1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[2]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, SC};
    vecs[3]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 4'd0, SC};
    vecs[4]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, SA};
    vecs[5]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[6]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, SC};
    vecs[7]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 4'd0, SC};
    vecs[8]  = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, SA};
    vecs[9]  = '{1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[10] = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, SC};
    vecs[11] = '{1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[12] = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, SC};
    vecs[13] = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[14] = '{1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};
    vecs[15] = '{1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, SC};
    // interval lowered to 01 with count already at 01: fires on this tick
    vecs[16] = '{1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, SA};
    vecs[17] = '{1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, SC};

    for (int v = 0; v < 18; v++) begin
      tens = vecs[v].tens;
      ones = vecs[v].ones;
      cyc(vecs[v].rst_n, vecs[v].tick, vecs[v].ack, vecs[v].snz, vecs[v].clr);
      chk($sformatf("vec%0d", v), vecs[v].e_min1, vecs[v].e_min0, vecs[v].e_alert,
          vecs[v].e_missed, vecs[v].e_state);
    end

    // BCD carry with invalid tens digit (EI = 60), then with interval 00.
    for (int pass = 0; pass < 2; pass++) begin
      tens = (pass == 0) ? 4'hA : 4'd0;
      ones = 4'd0;
      for (int i = 1; i <= 59; i++) begin
        ticks(1);
        chk($sformatf("ei60_p%0d_cnt%0d", pass, i), 4'(i / 10), 4'(i % 10), 1'b0, 4'd0, SC);
      end
      ticks(1);
      chk($sformatf("ei60_p%0d_alert", pass), 4'd0, 4'd0, 1'b1, 4'd0, SA);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("ei60_p%0d_ack", pass), 4'd0, 4'd0, 1'b0, 4'd0, SC);
    end

    // Timeouts: missedCount climbs to 9 and saturates.
    tens = 4'd0;
    ones = 4'd1;
    for (int k = 1; k <= 11; k++) miss_once(4'((k > 9) ? 9 : k));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_missed", 4'd0, 4'd0, 1'b0, 4'd0, SC);
    miss_once(4'd1);
    // clear coinciding with a timeout increment leaves zero
    ticks(10);
    chk("clr_race_pre", 4'd0, 4'd9, 1'b1, 4'd1, SA);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_race", 4'd0, 4'd0, 1'b0, 4'd0, SC);

    // Snooze path.
    ticks(1);
    chk("snz_alert", 4'd0, 4'd0, 1'b1, 4'd0, SA);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("snz_enter", 4'd0, 4'd0, 1'b0, 4'd0, SS);
    ticks(4);
    chk("snz_04", 4'd0, 4'd4, 1'b0, 4'd0, SS);
    ticks(1);
    chk("snz_realert", 4'd0, 4'd0, 1'b1, 4'd0, SA);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    chk("snz2_03", 4'd0, 4'd3, 1'b0, 4'd0, SS);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("snz_restart", 4'd0, 4'd0, 1'b0, 4'd0, SS);
    ticks(4);
    chk("snz_restart_04", 4'd0, 4'd4, 1'b0, 4'd0, SS);
    ticks(1);
    chk("snz_restart_alert", 4'd0, 4'd0, 1'b1, 4'd0, SA);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("snz_ack", 4'd0, 4'd0, 1'b0, 4'd0, SC);

    // Reset mid-alert with missedCount = 4.
    for (int k = 1; k <= 4; k++) miss_once(4'(k));
    ticks(3);
    chk("rst_pre", 4'd0, 4'd2, 1'b1, 4'd4, SA);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_alert", 4'd0, 4'd0, 1'b0, 4'd0, SC);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_hold", 4'd0, 4'd0, 1'b0, 4'd0, SC);
    tens = 4'd0;
    ones = 4'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_release", 4'd0, 4'd0, 1'b0, 4'd0, SC);
    ticks(1);
    chk("rst_first_tick", 4'd0, 4'd1, 1'b0, 4'd0, SC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
